// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
//   state_e : sweep FSM states
//   rows(n) : number of truth-table rows for an n-input block (2**n)
//   vote()  : majority decision for a count of ones out of a number of samples
package tt_sweep_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StSample,
    StDone
  } state_e;

  function automatic int unsigned rows(input int unsigned n);
    return 32'd1 << n;
  endfunction

  function automatic logic vote(input int unsigned ones, input int unsigned samples);
    return ones > (samples / 2);
  endfunction

endpackage

// File: rtl/majority_sampler.sv
// Counts ones on i_din while enabled and reports the majority vote.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : zero the ones counter (takes priority over i_enable)
//   i_enable     : count i_din this cycle
//   i_din        : sampled bit
//   o_vote       : majority over the counted ones plus the current i_din, so it is
//                  valid on the last enabled cycle before that sample is registered
module majority_sampler
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SAMPLES = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_din,
  output logic o_vote
);

  localparam int unsigned OW = $clog2(SAMPLES + 1);

  logic [OW-1:0] r_ones;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ones <= '0;
    end else if (i_clear) begin
      r_ones <= '0;
    end else if (i_enable && i_din) begin
      r_ones <= r_ones + 1'b1;
    end
  end

  assign o_vote = vote(32'(r_ones) + 32'(i_din), SAMPLES);

endmodule

// File: rtl/truth_table_sweep_ctrl.sv
// Sweeps an N_IN-input combinational block through all rows, majority-samples its output
// after a settle delay, and compares the measured table against an expected code.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_start      : begin a sweep (IDLE only; wins over i_abort)
//   i_abort      : cancel a sweep in APPLY/SETTLE/SAMPLE, no done pulse
//   i_expected   : target table, captured on the accepted start
//   o_dut_in     : logic-block inputs, in1 = MSB
//   i_dut_out    : logic-block output
//   o_busy       : sweep in progress
//   o_done       : one-cycle pulse, results valid in the same cycle
//   o_measured   : measured table, row 0 at the MSB
//   o_mismatch   : measured ^ expected
//   o_pass       : mismatch == 0
module truth_table_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN          = 3,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SAMPLES       = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [rows(N_IN)-1:0]     i_expected,
  output logic [N_IN-1:0]           o_dut_in,
  input  logic                      i_dut_out,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [rows(N_IN)-1:0]     o_measured,
  output logic [rows(N_IN)-1:0]     o_mismatch,
  output logic                      o_pass
);

  localparam int unsigned ROWS = rows(N_IN);
  localparam int unsigned SCW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SMW  = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam logic [N_IN:0] LAST_ROW = (N_IN + 1)'(ROWS - 1);

  state_e          r_state;
  logic [N_IN:0]   r_row;
  logic [SCW-1:0]  r_settle_cnt;
  logic [SMW-1:0]  r_samp_cnt;
  logic [ROWS-1:0] r_exp;
  logic [ROWS-1:0] r_shadow;
  logic [N_IN-1:0] r_dut_in;
  logic            r_busy;
  logic            r_done;
  logic [ROWS-1:0] r_measured;
  logic [ROWS-1:0] r_mismatch;
  logic            r_pass;

  logic            w_vote;
  logic            w_clear;
  logic            w_enable;
  logic            w_samp_last;
  logic            w_abort;
  logic [N_IN:0]   w_row_inc;
  logic [N_IN-1:0] w_bit_idx;
  logic [ROWS-1:0] w_shadow_nxt;

  assign w_clear     = (r_state == StApply);
  assign w_enable    = (r_state == StSample);
  assign w_samp_last = (r_samp_cnt == SMW'(SAMPLES - 1));
  assign w_abort     = i_abort &&
                       (r_state inside {StApply, StSettle, StSample});
  assign w_row_inc   = r_row + 1'b1;
  // ROWS is a power of two, so ROWS-1-row is the bitwise complement of row.
  assign w_bit_idx   = ~r_row[N_IN-1:0];

  // Shadow table including the vote of the row finishing this cycle; lets the final row
  // be committed on the same edge that enters DONE.
  always_comb begin
    w_shadow_nxt            = r_shadow;
    w_shadow_nxt[w_bit_idx] = w_vote;
  end

  majority_sampler #(
    .SAMPLES (SAMPLES)
  ) u_sampler (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .i_din    (i_dut_out),
    .o_vote   (w_vote)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_row        <= '0;
      r_settle_cnt <= '0;
      r_samp_cnt   <= '0;
      r_exp        <= '0;
      r_shadow     <= '0;
      r_dut_in     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_measured   <= '0;
      r_mismatch   <= '0;
      r_pass       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state  <= StIdle;
        r_dut_in <= '0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (i_start) begin
              r_exp    <= i_expected;
              r_row    <= '0;
              r_shadow <= '0;
              r_dut_in <= '0;
              r_busy   <= 1'b1;
              r_state  <= StApply;
            end
          end
          StApply: begin
            r_settle_cnt <= SCW'(SETTLE_CYCLES - 1);
            r_state      <= StSettle;
          end
          StSettle: begin
            if (r_settle_cnt == '0) begin
              r_samp_cnt <= '0;
              r_state    <= StSample;
            end else begin
              r_settle_cnt <= r_settle_cnt - 1'b1;
            end
          end
          StSample: begin
            if (w_samp_last) begin
              r_shadow <= w_shadow_nxt;
              if (r_row == LAST_ROW) begin
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_measured <= w_shadow_nxt;
                r_mismatch <= w_shadow_nxt ^ r_exp;
                r_pass     <= (w_shadow_nxt == r_exp);
                r_state    <= StDone;
              end else begin
                r_row    <= w_row_inc;
                r_dut_in <= w_row_inc[N_IN-1:0];
                r_state  <= StApply;
              end
            end else begin
              r_samp_cnt <= r_samp_cnt + 1'b1;
            end
          end
          StDone: begin
            r_dut_in <= '0;
            r_state  <= StIdle;
          end
          default: begin
            r_dut_in <= '0;
            r_busy   <= 1'b0;
            r_state  <= StIdle;
          end
        endcase
      end
    end
  end

  assign o_dut_in   = r_dut_in;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_measured = r_measured;
  assign o_mismatch = r_mismatch;
  assign o_pass     = r_pass;

endmodule
